// File: rtl/coll_pkg.sv
// coll_pkg: shared object/state types and pair-count sizing helpers for the collision pair scheduler
package coll_pkg;
  localparam int OBJ_W = 16;
  typedef struct packed {
    logic [OBJ_W-1:0] x;
    logic [OBJ_W-1:0] y;
    logic [OBJ_W-1:0] vx;
    logic [OBJ_W-1:0] vy;
  } obj_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} sched_state_t;
  function automatic int npair(input int n);
    return n * (n - 1) / 2;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(npair(n) + 1);
  endfunction
endpackage

// File: rtl/coll_pair_iter.sv
// coll_pair_iter: walks (i,j) over every pair i<j in row-major order; ports clock/reset, clear, advance -> i, j, last
module coll_pair_iter #(
  parameter int N_OBJ = 8,
  localparam int IDX_W = $clog2(N_OBJ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_OBJ - 1);
  assign last = i == IDX_W'(N_OBJ - 2) && j == LAST_J;
  // advancing from the final pair wraps back to (0,1)
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      i <= '0;
      j <= IDX_W'(1);
    end else if (clear || (advance && last)) begin
      i <= '0;
      j <= IDX_W'(1);
    end else if (advance) begin
      i <= j == LAST_J ? i + 1'b1 : i;
      j <= j == LAST_J ? i + IDX_W'(2) : j + 1'b1;
    end
endmodule

// File: rtl/coll_pair_sched.sv
// coll_pair_sched: sweeps all object pairs of a host-loaded table through one collision detector
// Ports: host load_*/r2/start in; busy, done, hit_valid/hit_i/hit_j, hit_count, err_timeout out;
// detector side det_req + det_* operands out, det_done/det_hit in.
// Build option COLL_SCHED_EARLY_EXIT_EN: finish the sweep right after the first reported hit.
module coll_pair_sched
  import coll_pkg::*;
#(
  parameter int N_OBJ = 8,
  parameter int W = OBJ_W,
  parameter int TIMEOUT = 32,
  localparam int IDX_W = $clog2(N_OBJ),
  localparam int CNT_W = cnt_w(N_OBJ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [W-1:0]     load_x,
  input  logic [W-1:0]     load_y,
  input  logic [W-1:0]     load_vx,
  input  logic [W-1:0]     load_vy,
  input  logic [W-1:0]     r2,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             hit_valid,
  output logic [IDX_W-1:0] hit_i,
  output logic [IDX_W-1:0] hit_j,
  output logic [CNT_W-1:0] hit_count,
  output logic             err_timeout,
  output logic             det_req,
  output logic [W-1:0]     det_x1,
  output logic [W-1:0]     det_y1,
  output logic [W-1:0]     det_vx1,
  output logic [W-1:0]     det_vy1,
  output logic [W-1:0]     det_x2,
  output logic [W-1:0]     det_y2,
  output logic [W-1:0]     det_vx2,
  output logic [W-1:0]     det_vy2,
  output logic [W-1:0]     det_r2,
  input  logic             det_done,
  input  logic             det_hit
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  sched_state_t state, state_n;
  obj_t tbl [N_OBJ];
  logic [IDX_W-1:0] i, j;
  logic [WD_W-1:0] wdog;
  logic [W-1:0] r2_q;
  logic last, early, fire, hit_now, wd_exp;
  assign fire = state == IDLE && start;
  assign hit_now = state == WAIT && det_done && det_hit;
  assign wd_exp = state == WAIT && wdog == WD_W'(TIMEOUT - 1);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign det_req = state == ISSUE || state == WAIT;
  assign det_r2 = r2_q;
  assign det_x1 = tbl[i].x;
  assign det_y1 = tbl[i].y;
  assign det_vx1 = tbl[i].vx;
  assign det_vy1 = tbl[i].vy;
  assign det_x2 = tbl[j].x;
  assign det_y2 = tbl[j].y;
  assign det_vx2 = tbl[j].vx;
  assign det_vy2 = tbl[j].vy;
  // in NEXT, hit_valid is exactly the outcome of the pair just finished
`ifdef COLL_SCHED_EARLY_EXIT_EN
  assign early = hit_valid;
`else
  assign early = 1'b0;
`endif
  coll_pair_iter #(.N_OBJ(N_OBJ)) u_iter (
    .clock(clock), .reset(reset), .clear(fire), .advance(state == NEXT),
    .i(i), .j(j), .last(last)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = fire ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = det_done || wd_exp ? NEXT : WAIT;
      NEXT:    state_n = last || early ? FINISH : ISSUE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int k = 0; k < N_OBJ; k++) tbl[k] <= '0;
      wdog <= '0;
      r2_q <= '0;
      hit_valid <= 1'b0;
      hit_i <= '0;
      hit_j <= '0;
      hit_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      hit_valid <= hit_now;
      wdog <= state == WAIT ? wdog + 1'b1 : '0;
      if (state == IDLE && load_en)
        tbl[load_idx] <= '{x: load_x, y: load_y, vx: load_vx, vy: load_vy};
      if (fire) begin
        r2_q <= r2;
        hit_count <= '0;
        err_timeout <= 1'b0;
      end
      if (hit_now) begin
        hit_i <= i;
        hit_j <= j;
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
      if (wd_exp && !det_done) err_timeout <= 1'b1;
    end
endmodule
